// File: rtl/mem_mesh_q.sv
// mem_mesh_q: per-core DFF RAM blocks joined by a tree-shaped write-spread
// interconnect, with per-port IO input cells and buffered IO output queues.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   we/waddr/wspread/wdata  per-core write request (wspread selects subtree size)
//   raddr/rdata     per-core read of its own block (combinational or registered)
//   io_in_*         per-port valid/ready input writing cell IO_FIRST+p in every block
//   io_out_*        per-port valid/ready output queue fed by IO broadcasts
//   io_ovf_cnt      per-port saturating 8-bit count of words dropped on a full queue
module mem_mesh_q #(
  parameter int unsigned CORES        = 8,
  parameter int unsigned LOG_CORES    = 3,
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SPREAD_WIDTH = 3,
  parameter int unsigned IO_PORTS     = 4,
  parameter int unsigned IO_FIRST     = 8,
  parameter int unsigned OUTQ_DEPTH   = 4,
  parameter int unsigned READ_REG     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORES-1:0]                 we,
  input  logic [CORES*ADDR_WIDTH-1:0]      waddr,
  input  logic [CORES*SPREAD_WIDTH-1:0]    wspread,
  input  logic [CORES*DATA_WIDTH-1:0]      wdata,
  input  logic [CORES*ADDR_WIDTH-1:0]      raddr,
  output logic [CORES*DATA_WIDTH-1:0]      rdata,
  input  logic [IO_PORTS-1:0]              io_in_valid,
  output logic [IO_PORTS-1:0]              io_in_ready,
  input  logic [IO_PORTS*DATA_WIDTH-1:0]   io_in_data,
  output logic [IO_PORTS-1:0]              io_out_valid,
  input  logic [IO_PORTS-1:0]              io_out_ready,
  output logic [IO_PORTS*DATA_WIDTH-1:0]   io_out_data,
  output logic [IO_PORTS*8-1:0]            io_ovf_cnt
);

  localparam logic [SPREAD_WIDTH-1:0] SpreadAll   = SPREAD_WIDTH'(LOG_CORES);
  localparam logic [SPREAD_WIDTH-1:0] SpreadBcast = SPREAD_WIDTH'(LOG_CORES + 1);
  localparam int unsigned QAw  = $clog2(OUTQ_DEPTH);
  localparam int unsigned PtrW = QAw + 1;

  assign io_in_ready = {IO_PORTS{~rst}};

  // ---------------------------------------------------------------------------
  // RAM blocks: each block resolves its own per-cell winner among the cores
  // whose spread reaches it.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < CORES; b++) begin : g_blk
    localparam int unsigned BlkIdx = b;

    logic [DATA_WIDTH-1:0]   row_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   row_d [MEM_DEPTH];
    logic [SPREAD_WIDTH-1:0] best  [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]    taken;
    logic [SPREAD_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0]   wa;
    logic [ADDR_WIDTH-1:0]   ra;
    logic                    hit;

    always_comb begin
      row_d = row_q;
      taken = '0;
      k     = '0;
      wa    = '0;
      hit   = 1'b0;
      for (int unsigned a = 0; a < MEM_DEPTH; a++) best[a] = '0;
      // Ascending core order with a strict compare keeps the lowest core on ties.
      for (int unsigned c = 0; c < CORES; c++) begin
        k   = wspread[c*SPREAD_WIDTH +: SPREAD_WIDTH];
        wa  = waddr[c*ADDR_WIDTH +: ADDR_WIDTH];
        hit = we[c] && ((k >= SpreadAll) || ((BlkIdx >> k) == (c >> k)));
        if (hit && (!taken[wa] || (k > best[wa]))) begin
          taken[wa] = 1'b1;
          best[wa]  = k;
          row_d[wa] = wdata[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // IO input overrides any core write to its cell.
      for (int unsigned p = 0; p < IO_PORTS; p++) begin
        if (io_in_valid[p]) begin
          row_d[ADDR_WIDTH'(IO_FIRST + p)] = io_in_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned a = 0; a < MEM_DEPTH; a++) row_q[a] <= '0;
      end else begin
        row_q <= row_d;
      end
    end

    assign ra = raddr[b*ADDR_WIDTH +: ADDR_WIDTH];

    if (READ_REG != 0) begin : g_rreg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= row_q[ra];
      end
      assign rdata[b*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end else begin : g_rcomb
      assign rdata[b*DATA_WIDTH +: DATA_WIDTH] = row_q[ra];
    end
  end

  // ---------------------------------------------------------------------------
  // Output queues: a broadcast-spread write that wins its IO cell is queued
  // even when an IO input overrides the cell contents.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < IO_PORTS; p++) begin : g_port
    localparam logic [ADDR_WIDTH-1:0] Cell = ADDR_WIDTH'(IO_FIRST + p);

    logic [DATA_WIDTH-1:0]   slot_q [OUTQ_DEPTH];
    logic [PtrW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]              ovf_q, ovf_d;
    logic [SPREAD_WIDTH-1:0] best, k;
    logic [DATA_WIDTH-1:0]   push_data;
    logic                    found, push, full, empty, pop, do_push;

    always_comb begin
      found     = 1'b0;
      best      = '0;
      k         = '0;
      push_data = '0;
      for (int unsigned c = 0; c < CORES; c++) begin
        k = wspread[c*SPREAD_WIDTH +: SPREAD_WIDTH];
        if (we[c] && (waddr[c*ADDR_WIDTH +: ADDR_WIDTH] == Cell) && (!found || (k > best))) begin
          found     = 1'b1;
          best      = k;
          push_data = wdata[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      push = found && (best == SpreadBcast);
    end

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[QAw] != rptr_q[QAw]) && (wptr_q[QAw-1:0] == rptr_q[QAw-1:0]);
    assign pop     = ~empty & io_out_ready[p];
    assign do_push = push & (~full | pop);

    always_comb begin
      wptr_d = wptr_q + PtrW'(do_push);
      rptr_d = rptr_q + PtrW'(pop);
      ovf_d  = ovf_q;
      if (push && full && !pop && (ovf_q != 8'hff)) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        ovf_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        ovf_q  <= ovf_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && do_push) slot_q[wptr_q[QAw-1:0]] <= push_data;
    end

    assign io_out_valid[p]                          = ~empty;
    assign io_out_data[p*DATA_WIDTH +: DATA_WIDTH]  = empty ? '0 : slot_q[rptr_q[QAw-1:0]];
    assign io_ovf_cnt[p*8 +: 8]                     = ovf_q;
  end

endmodule

// File: tb/tb_mem_mesh_q.sv
// Self-checking bench for mem_mesh_q: directed scenarios plus random traffic,
// checked against an array/queue reference model. Two instances (combinational
// and registered read) share all inputs.
module tb_mem_mesh_q;
  localparam int CORES = 8, LC = 3, MD = 16, AW = 4, DW = 16, SW = 3;
  localparam int NP = 4, IOF = 8, QD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CORES-1:0]     we;
  logic [CORES*AW-1:0]  waddr, raddr;
  logic [CORES*SW-1:0]  wspread;
  logic [CORES*DW-1:0]  wdata;
  logic [NP-1:0]        io_in_valid, io_out_ready;
  logic [NP*DW-1:0]     io_in_data;

  logic [CORES*DW-1:0]  rdata_c, rdata_r;
  logic [NP-1:0]        in_rdy_c, in_rdy_r, ov_c, ov_r;
  logic [NP*DW-1:0]     od_c, od_r;
  logic [NP*8-1:0]      ovf_c, ovf_r;

  mem_mesh_q #(.READ_REG(0)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wspread(wspread), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_c), .io_in_valid(io_in_valid), .io_in_ready(in_rdy_c),
    .io_in_data(io_in_data), .io_out_valid(ov_c), .io_out_ready(io_out_ready),
    .io_out_data(od_c), .io_ovf_cnt(ovf_c)
  );

  mem_mesh_q #(.READ_REG(1)) u_dut_r (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wspread(wspread), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_r), .io_in_valid(io_in_valid), .io_in_ready(in_rdy_r),
    .io_in_data(io_in_data), .io_out_valid(ov_r), .io_out_ready(io_out_ready),
    .io_out_data(od_r), .io_ovf_cnt(ovf_r)
  );

  always #5 clk = ~clk;

  // Reference model state (state after the most recent rising edge).
  int m [CORES][MD];
  int rexp1 [CORES];
  int cnt [NP];
  int ovf [NP];
  int sb [NP][$];
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int wsp [CORES][MD];
    int wd  [CORES][MD];
    if (rst) begin
      for (int b = 0; b < CORES; b++) begin
        for (int a = 0; a < MD; a++) m[b][a] = 0;
        rexp1[b] = 0;
      end
      for (int p = 0; p < NP; p++) begin
        cnt[p] = 0;
        ovf[p] = 0;
        sb[p].delete();
      end
      return;
    end
    for (int c = 0; c < CORES; c++) rexp1[c] = m[c][raddr[c*AW +: AW]];
    for (int b = 0; b < CORES; b++)
      for (int a = 0; a < MD; a++) begin
        wsp[b][a] = -1;
        wd[b][a]  = 0;
      end
    // A spread of k covers the aligned group of 2**k blocks containing the core.
    for (int c = 0; c < CORES; c++) begin
      if (we[c]) begin
        int k, a, lo, n;
        k  = int'(wspread[c*SW +: SW]);
        a  = int'(waddr[c*AW +: AW]);
        lo = (k >= LC) ? 0 : ((c >> k) << k);
        n  = (k >= LC) ? CORES : (1 << k);
        for (int b = lo; b < lo + n; b++) begin
          if (k > wsp[b][a]) begin
            wsp[b][a] = k;
            wd[b][a]  = int'(wdata[c*DW +: DW]);
          end
        end
      end
    end
    for (int b = 0; b < CORES; b++)
      for (int a = 0; a < MD; a++)
        if (wsp[b][a] >= 0) m[b][a] = wd[b][a];
    for (int p = 0; p < NP; p++)
      if (io_in_valid[p])
        for (int b = 0; b < CORES; b++) m[b][IOF + p] = int'(io_in_data[p*DW +: DW]);
    for (int p = 0; p < NP; p++) begin
      int best, bd;
      best = -1;
      bd   = 0;
      for (int c = 0; c < CORES; c++) begin
        if (we[c] && int'(waddr[c*AW +: AW]) == IOF + p && int'(wspread[c*SW +: SW]) > best) begin
          best = int'(wspread[c*SW +: SW]);
          bd   = int'(wdata[c*DW +: DW]);
        end
      end
      if (cnt[p] > 0 && io_out_ready[p]) cnt[p]--;
      if (best == LC + 1) begin
        if (cnt[p] < QD) begin
          sb[p].push_back(bd);
          cnt[p]++;
        end else if (ovf[p] < 255) begin
          ovf[p]++;
        end
      end
    end
  endtask

  // Inputs change at negedge+1; model advances at each rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    io_in_valid = '0;
    rst         = 1'b0;
  endtask

  task automatic set_write(input int c, input int a, input int k, input int d);
    we[c]                 = 1'b1;
    waddr[c*AW +: AW]     = AW'(a);
    wspread[c*SW +: SW]   = SW'(k);
    wdata[c*DW +: DW]     = DW'(d);
  endtask

  task automatic read_all(input int a);
    for (int c = 0; c < CORES; c++) raddr[c*AW +: AW] = AW'(a);
  endtask

  // Monitor: compares every cycle just before the rising edge; pops the
  // scoreboard whenever the DUT hands over a queue word.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        for (int c = 0; c < CORES; c++) begin
          chk($sformatf("rdata_comb[%0d]", c), 32'(rdata_c[c*DW +: DW]), m[c][raddr[c*AW +: AW]]);
          chk($sformatf("rdata_reg[%0d]", c), 32'(rdata_r[c*DW +: DW]), rexp1[c]);
        end
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("io_in_ready[%0d]", p), 32'(in_rdy_c[p]), 32'(!rst));
          chk($sformatf("io_out_valid[%0d]", p), 32'(ov_c[p]), 32'(cnt[p] > 0));
          chk($sformatf("io_out_valid_r[%0d]", p), 32'(ov_r[p]), 32'(cnt[p] > 0));
          chk($sformatf("io_ovf_cnt[%0d]", p), 32'(ovf_c[p*8 +: 8]), ovf[p]);
          chk($sformatf("io_ovf_cnt_r[%0d]", p), 32'(ovf_r[p*8 +: 8]), ovf[p]);
          if (ov_c[p] && io_out_ready[p]) begin
            if (sb[p].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL queue_pop[%0d]: got a word, expected an empty queue", p);
            end else begin
              int e;
              e = sb[p].pop_front();
              chk($sformatf("io_out_data[%0d]", p), 32'(od_c[p*DW +: DW]), e);
              chk($sformatf("io_out_data_r[%0d]", p), 32'(od_r[p*DW +: DW]), e);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = '0; waddr = '0; raddr = '0; wspread = '0; wdata = '0;
    io_in_valid = '0; io_in_data = '0; io_out_ready = '0;
    @(negedge clk);
    #1;
    tick();
    tick();
    idle();
    mon_en = 1'b1;
    #3;
    chk("reset_out_data", 32'(od_c), 0);
    tick();

    // Higher spread wins everywhere, including the other core's subtree.
    set_write(2, 3, 3, 'hAAAA);
    set_write(5, 3, 2, 'h5555);
    tick();
    idle();
    read_all(3);
    #3;
    for (int c = 0; c < CORES; c++) chk($sformatf("spread_win[%0d]", c), 32'(rdata_c[c*DW +: DW]), 'hAAAA);
    tick();

    // Equal spread: lowest core wins; only blocks 0,1 touched.
    set_write(0, 2, 1, 'h0011);
    set_write(1, 2, 1, 'h0022);
    tick();
    idle();
    read_all(2);
    #3;
    for (int c = 0; c < CORES; c++)
      chk($sformatf("tie_subtree[%0d]", c), 32'(rdata_c[c*DW +: DW]), (c < 2) ? 'h0011 : 0);
    tick();

    // Broadcast to port 1.
    set_write(3, IOF + 1, LC + 1, 'h1234);
    tick();
    idle();
    read_all(IOF + 1);
    #3;
    chk("bcast_valid", 32'(ov_c[1]), 1);
    chk("bcast_data", 32'(od_c[DW +: DW]), 'h1234);
    for (int c = 0; c < CORES; c++) chk($sformatf("bcast_mem[%0d]", c), 32'(rdata_c[c*DW +: DW]), 'h1234);
    tick();

    // IO input overrides the cell, queue still takes the core word.
    set_write(3, IOF + 1, LC + 1, 'h1234);
    io_in_valid[1]          = 1'b1;
    io_in_data[DW +: DW]    = 'hBEEF;
    tick();
    idle();
    #3;
    for (int c = 0; c < CORES; c++) chk($sformatf("io_override[%0d]", c), 32'(rdata_c[c*DW +: DW]), 'hBEEF);
    chk("override_q_head", 32'(od_c[DW +: DW]), 'h1234);
    tick();

    // Six broadcasts into a 4-deep queue: two drops, then drain in order.
    for (int i = 0; i < 6; i++) begin
      idle();
      set_write(i, IOF, LC + 1, 'h100 + i);
      tick();
    end
    idle();
    #3;
    chk("ovf_after_6", 32'(ovf_c[7:0]), 2);
    tick();
    io_out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("drain_valid[%0d]", i), 32'(ov_c[0]), 1);
      chk($sformatf("drain_data[%0d]", i), 32'(od_c[DW-1:0]), 'h100 + i);
      tick();
    end
    #3;
    chk("drained_empty", 32'(ov_c[0]), 0);
    tick();

    // Reset in the middle of a drain.
    io_out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      idle();
      set_write(7, IOF, LC + 1, 'h200 + i);
      tick();
    end
    idle();
    io_out_ready[0] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    chk("rst_mid_valid", 32'(ov_c[0]), 0);
    chk("rst_mid_ovf", 32'(ovf_c[7:0]), 0);
    chk("rst_mid_data", 32'(od_c[DW-1:0]), 0);
    tick();

    // Registered read returns pre-write data on collision.
    read_all(5);
    set_write(0, 5, LC, 'h7777);
    tick();
    idle();
    #3;
    chk("rreg_collide", 32'(rdata_r[DW-1:0]), 0);
    chk("rcomb_after", 32'(rdata_c[DW-1:0]), 'h7777);
    tick();
    #3;
    chk("rreg_next", 32'(rdata_r[DW-1:0]), 'h7777);
    tick();

    // Overflow counter saturates.
    io_out_ready = '0;
    for (int i = 0; i < 260; i++) begin
      idle();
      set_write(7, IOF + 2, LC + 1, i);
      tick();
    end
    idle();
    #3;
    chk("ovf_saturate", 32'(ovf_c[23:16]), 255);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random traffic, biased toward IO cells and broadcast spreads.
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CORES; c++) begin
        we[c]               = ($urandom_range(0, 1) == 1);
        waddr[c*AW +: AW]   = ($urandom_range(0, 1) == 1) ? AW'(IOF + $urandom_range(0, NP - 1))
                                                           : AW'($urandom_range(0, MD - 1));
        wspread[c*SW +: SW] = SW'($urandom_range(0, LC + 1));
        wdata[c*DW +: DW]   = DW'($urandom);
        raddr[c*AW +: AW]   = AW'($urandom_range(0, MD - 1));
      end
      for (int p = 0; p < NP; p++) begin
        io_in_valid[p]         = ($urandom_range(0, 7) == 0);
        io_in_data[p*DW +: DW] = DW'($urandom);
        io_out_ready[p]        = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_mesh_q.md
# mem_mesh_q

Parametrised successor to the core memory mesh: one DFF RAM block per CPU core, a tree-shaped write-spread interconnect between blocks, and per-port IO channels. It adds Verilog parameters instead of global defines, an optional registered read port, and a buffered, handshaked IO output queue per port with a saturating overflow counter. It sits between the cores and the IO pads.

## Interface

Parameters:
- CORES, 8: number of cores and RAM blocks; power of two.
- LOG_CORES, 3: clog2(CORES).
- MEM_DEPTH, 16: words per block.
- ADDR_WIDTH, 4: clog2(MEM_DEPTH).
- DATA_WIDTH, 16: word width.
- SPREAD_WIDTH, 3: clog2(2+LOG_CORES).
- IO_PORTS, 4: IO channels; IO_FIRST+IO_PORTS <= MEM_DEPTH.
- IO_FIRST, 8: cell mapped to port 0; port p maps to cell IO_FIRST+p.
- OUTQ_DEPTH, 4: output queue entries per port; power of two >= 2.
- READ_REG, 0: 0 = combinational read, 1 = registered read.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- we  in  CORES  per-core write enable.
- waddr  in  CORES*ADDR_WIDTH  write address.
- wspread  in  CORES*SPREAD_WIDTH  write spread.
- wdata  in  CORES*DATA_WIDTH  write data.
- raddr  in  CORES*ADDR_WIDTH  read address.
- rdata  out  CORES*DATA_WIDTH  read data.
- io_in_valid  in  IO_PORTS  incoming word present.
- io_in_ready  out  IO_PORTS  incoming word accepted.
- io_in_data  in  IO_PORTS*DATA_WIDTH  incoming word.
- io_out_valid  out  IO_PORTS  queue head valid.
- io_out_ready  in  IO_PORTS  consumer takes head.
- io_out_data  out  IO_PORTS*DATA_WIDTH  queue head.
- io_ovf_cnt  out  IO_PORTS*8  dropped-word counter per port.

## Operation

- Spread: a write from core c with wspread=k targets the same address in every block whose index equals c in all bits above bit k-1. k=0 targets only block c. k>=LOG_CORES targets all blocks. k=LOG_CORES+1 additionally marks an IO broadcast.
- Priority per cell: higher wspread wins. On equal wspread, the lowest core index wins. The winner is resolved independently per block, so a low-spread write still lands in its own subtree when a higher-spread write targets other subtrees.
- IO broadcast: a winning write with wspread=LOG_CORES+1 to cell IO_FIRST+p pushes the winning data into output queue p.
- IO input: io_in_valid[p] & io_in_ready[p] writes io_in_data[p] to cell IO_FIRST+p in all blocks. It overrides every core write to that cell. It is never pushed into the output queue (no loopback).
- io_in_ready = !rst.
- Output queue p: FIFO holding OUTQ_DEPTH words. A pop occurs on io_out_valid & io_out_ready.
  - Push to a full queue with a pop in the same cycle: both happen; the count is unchanged.
  - Push to a full queue without a pop: the word is dropped and io_ovf_cnt[p] increments, saturating at 255.
  - Pop from an empty queue: no effect.
- Pointers wrap modulo OUTQ_DEPTH. Use an extra pointer bit to distinguish full from empty.

## Timing

- Memory writes and queue pushes commit on the rising clk edge of the cycle in which they are requested.
- READ_REG=0: rdata = mem[raddr] combinationally. A same-cycle write is visible only after the edge.
- READ_REG=1: rdata registered, 1-cycle latency. It returns pre-write data on a read/write collision.
- Queue is not fall-through: a push into an empty queue raises io_out_valid on the next cycle. io_out_data is stable while valid & !ready.
- Reset (any cycle, including mid-stream):
  - all cells = 0, queues emptied, io_out_valid = 0, io_out_data = 0, io_ovf_cnt = 0, registered rdata = 0;
  - writes and pushes requested during rst are ignored.

## Test plan

- Cores 2 and 5 both write addr 3, wspread=3 and 2, data 0xAAAA/0x5555 -> blocks 4-7 hold 0x5555 only if core 5 wins its subtree. Required: all 8 blocks = 0xAAAA, because the higher spread wins.
- Cores 0 and 1 write addr 2, wspread=1, data 0x0011/0x0022 -> blocks 0,1 = 0x0011; blocks 2-7 unchanged (0).
- Core 3 writes cell IO_FIRST+1, wspread=4, data 0x1234, io_out_ready=0 -> io_out_valid[1]=1 next cycle with 0x1234; all blocks hold 0x1234.
- Same cell, io_in_valid[1] with 0xBEEF in the same cycle as core write 0x1234 wspread=4 -> all blocks = 0xBEEF; queue 1 receives 0x1234.
- 6 broadcasts to port 0 with io_out_ready=0, OUTQ_DEPTH=4 -> io_ovf_cnt[0]=2. Then drain: data pops in order of the first four words.
- READ_REG=1: write 0x7777 to addr 5 while reading addr 5 -> rdata=0 next cycle, 0x7777 the cycle after. Assert rst mid-drain -> io_out_valid=0 and io_ovf_cnt=0 on the next cycle.
